// File: rtl/boiler_fill_ctrl.sv
// Fill-state controller for one boiler sprite: stacks up to four colour layers via timed pours.
// Define BOILER_UNDO_EN to enable removing the top layer with undo_pulse while selected.
module boiler_fill_ctrl #(
  parameter int POUR_TICKS = 4,
  parameter int MAX_LAYERS = 4
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic       tick,
  input  logic       sel_pulse,
  input  logic       pour_req,
  input  logic [2:0] pour_colour,
  input  logic       undo_pulse,
  input  logic       confirm_pulse,
  input  logic       clear_pulse,
  output logic [2:0] colour1,
  output logic [2:0] colour2,
  output logic [2:0] colour3,
  output logic [2:0] colour4,
  output logic       selected,
  output logic       confirmed,
  output logic [2:0] level,
  output logic       busy,
  output logic       pour_done,
  output logic       pour_err
);

  typedef enum logic [1:0] {IDLE, SEL, POUR, DONE} state_t;

  localparam logic [3:0] LAST_TICK = 4'(POUR_TICKS - 1);
  localparam logic [2:0] FULL      = 3'(MAX_LAYERS);

  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] pour_col;
  logic [2:0] layer [0:3];
  logic       undo_hit;
  logic       colour_ok;
  logic       pour_ok;

`ifdef BOILER_UNDO_EN
  logic [2:0] level_dec;
  assign undo_hit  = undo_pulse;
  assign level_dec = level - 3'd1;
`else
  logic undo_unused;
  assign undo_hit    = 1'b0;
  assign undo_unused = undo_pulse;
`endif

  // A pour is only taken from SEL when no higher-priority pulse competes in the same cycle.
  assign colour_ok = (pour_colour != 3'b000) && (pour_colour != 3'b111);
  assign pour_ok   = pour_req && colour_ok && (level < FULL) && (state == SEL) &&
                     !clear_pulse && !sel_pulse && !confirm_pulse && !undo_hit;

  assign colour1 = layer[0];
  assign colour2 = layer[1];
  assign colour3 = layer[2];
  assign colour4 = layer[3];

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      tick_cnt  <= 4'd0;
      pour_col  <= 3'b000;
      level     <= 3'd0;
      selected  <= 1'b0;
      confirmed <= 1'b0;
      busy      <= 1'b0;
      pour_done <= 1'b0;
      pour_err  <= 1'b0;
      for (int i = 0; i < 4; i++) layer[i] <= 3'b000;
    end else begin
      pour_done <= 1'b0;
      pour_err  <= pour_req && !pour_ok;
      if (clear_pulse) begin
        state     <= IDLE;
        tick_cnt  <= 4'd0;
        level     <= 3'd0;
        selected  <= 1'b0;
        confirmed <= 1'b0;
        busy      <= 1'b0;
        for (int i = 0; i < 4; i++) layer[i] <= 3'b000;
      end else begin
        case (state)
          IDLE: begin
            if (sel_pulse) begin
              state    <= SEL;
              selected <= 1'b1;
            end
          end
          SEL: begin
            if (sel_pulse) begin
              state    <= IDLE;
              selected <= 1'b0;
            end else if (confirm_pulse && (level != 3'd0)) begin
              state     <= DONE;
              selected  <= 1'b0;
              confirmed <= 1'b1;
`ifdef BOILER_UNDO_EN
            end else if (undo_pulse && (level != 3'd0)) begin
              layer[level_dec[1:0]] <= 3'b000;
              level                 <= level_dec;
`endif
            end else if (pour_ok) begin
              state    <= POUR;
              pour_col <= pour_colour;
              tick_cnt <= 4'd0;
              busy     <= 1'b1;
            end
          end
          POUR: begin
            if (tick) begin
              if (tick_cnt == LAST_TICK) begin
                layer[level[1:0]] <= pour_col;
                level             <= level + 3'd1;
                pour_done         <= 1'b1;
                busy              <= 1'b0;
                state             <= SEL;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/boiler_fill_ctrl.md
Name: boiler_fill_ctrl

Overview:
- Sequential controller that owns the fill state of one on-screen boiler sprite.
- Accepts select, pour, undo, confirm and clear pulses from the game/input layer, animates each pour over a number of frame ticks, and stacks up to four colour layers bottom-up.
- Drives the boiler renderer directly downstream: colour1..colour4 (3-bit codes), selected and confirmed.

Parameters:
- POUR_TICKS, 4, frame ticks one pour takes before its layer commits (1..15).
- MAX_LAYERS, 4, layer capacity; fixed at 4 to match the renderer.

Ports:
- CLOCK  in  1  system clock
- RESETN  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame-rate enable
- sel_pulse  in  1  toggle selection of this boiler
- pour_req  in  1  one-cycle pour request
- pour_colour  in  3  colour code for pour_req; valid codes 001..110
- undo_pulse  in  1  remove top layer
- confirm_pulse  in  1  lock the boiler
- clear_pulse  in  1  empty and reset the boiler
- colour1  out  3  bottom layer code (000 = empty/white)
- colour2  out  3  layer 2 code
- colour3  out  3  layer 3 code
- colour4  out  3  top layer code
- selected  out  1  cap shows selected
- confirmed  out  1  cap shows confirmed
- level  out  3  committed layers, 0..4
- busy  out  1  pour in progress
- pour_done  out  1  one-cycle pulse when a layer commits
- pour_err  out  1  one-cycle pulse when a pour_req is rejected

Behaviour:
- Clock and reset: one clock, CLOCK; reset is asynchronous and active-low, RESETN.
- Reset values:
  - all colourN = 000, level = 0
  - selected = confirmed = busy = pour_done = pour_err = 0
  - state IDLE, tick counter 0
- All outputs are registered.
- Input priority in any one cycle: clear > sel > confirm > undo > pour.

States:
- IDLE:
  - selected = 0.
  - sel_pulse -> SEL.
  - pour_req -> pour_err.
- SEL:
  - selected = 1.
  - sel_pulse -> IDLE.
  - confirm_pulse with level >= 1 -> DONE. With level = 0 it is ignored.
  - undo: see Optional Feature.
  - pour_req with pour_colour in 001..110 and level < 4 -> latch the colour, counter = 0, go to POUR, busy = 1 next cycle.
  - Any other pour_req -> pour_err for one cycle, no state change. This covers code 000, code 111, level = 4, and a pour in the same cycle as a higher-priority input.
- POUR:
  - busy = 1, selected = 1.
  - Counter increments on each tick. When the counter reaches POUR_TICKS - 1 and tick is high:
    - write the latched colour into layer[level]: level 0 -> colour1 ... level 3 -> colour4
    - level = level + 1
    - pour_done = 1 for one cycle
    - busy = 0
    - go to SEL
  - sel_pulse, confirm_pulse and undo_pulse are ignored.
  - pour_req -> pour_err.
- DONE:
  - confirmed = 1, selected = 0.
  - Only clear_pulse exits.
  - All other inputs are ignored; pour_req -> pour_err.
- clear_pulse (any state): next cycle is IDLE with all layers 000, level 0, counter 0, busy 0, no pour_done. An in-flight pour is discarded.
- Layer codes are written only at commit or undo; they never change mid-pour.
- level never exceeds 4 and never wraps below 0.
- Reset asserted mid-pour: same effect as clear, applied asynchronously.

Optional Feature:
- Macro: BOILER_UNDO_EN.
- Defined: in SEL, undo_pulse with level > 0 sets layer[level-1] = 000 and level = level - 1 in one cycle. undo_pulse with level = 0 is ignored.
- Not defined: undo_pulse is ignored in every state. The port remains present and no undo logic is synthesised.

Test Plan:
- Reset, then sel_pulse, then pour_req with colour 010 and POUR_TICKS = 4, followed by 4 ticks -> busy high from the cycle after pour_req; pour_done on the 4th tick; colour1 = 010, level = 1, busy = 0.
- Four valid pours (001, 011, 100, 101), then a fifth pour_req -> colour1..4 = 001/011/100/101, level = 4; the fifth pour yields pour_err = 1 and no state change.
- pour_req with colour 111, then with 000, while in SEL -> pour_err each time, level unchanged, busy stays 0.
- Mid-pour (after 2 ticks) clear_pulse -> next cycle state IDLE, busy = 0, all colours 000, level 0, no pour_done.
- With level = 2: confirm_pulse -> confirmed = 1, selected = 0; then sel_pulse and pour_req are ignored (pour_err = 1); clear_pulse -> confirmed = 0, level 0.
- BOILER_UNDO_EN defined, level = 3 -> undo_pulse gives colour3 = 000, level = 2. Macro undefined -> the same stimulus leaves colour3 and level unchanged.
